// File: rtl/otg_hpi_pio_pkg.sv
// rtl/otg_hpi_pio_pkg.sv - register offsets and edge-type constants for otg_hpi_pio
package otg_hpi_pio_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/otg_hpi_pio_sync.sv
// rtl/otg_hpi_pio_sync.sv - input synchroniser chain with delayed copy and edge pulses
module otg_hpi_pio_sync
    import otg_hpi_pio_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync,
    output logic [WIDTH-1:0] o_edge
);

    logic [WIDTH-1:0] r_chain [SYNC_STAGES];
    logic [WIDTH-1:0] r_dly;
    logic [WIDTH-1:0] w_edge;

    // Shift pins through the metastability chain; the delayed copy runs
    // regardless of direction so a dir change never looks like an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_chain[i] <= '0;
            end
            r_dly <= '0;
        end else begin
            r_chain[0] <= i_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
            r_dly <= r_chain[SYNC_STAGES-1];
        end
    end

    // Compare synchronised value with its delayed copy for the selected edge.
    always_comb begin
        w_edge = '0;
        case (EDGE_TYPE)
            EDGE_FALL: w_edge = ~r_chain[SYNC_STAGES-1] & r_dly;
            EDGE_ANY:  w_edge =  r_chain[SYNC_STAGES-1] ^ r_dly;
            default:   w_edge =  r_chain[SYNC_STAGES-1] & ~r_dly;
        endcase
    end

    assign o_sync = r_chain[SYNC_STAGES-1];
    assign o_edge = w_edge;

endmodule

// File: rtl/otg_hpi_pio.sv
// rtl/otg_hpi_pio.sv - Avalon-MM GPIO port with edge capture and IRQ; OTG_HPI_PIO_SETCLR_EN enables OUTSET/OUTCLR
module otg_hpi_pio
    import otg_hpi_pio_pkg::*;
#(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [WIDTH-1:0] DIR_RESET   = '0,
    parameter int               EDGE_TYPE   = EDGE_RISE,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    logic [WIDTH-1:0] r_data_out;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_irq_mask;
    logic [WIDTH-1:0] r_edge_cap;

    logic             w_wr;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_sync_in;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_cap_clr;
    logic [31:0]      w_read;
    logic             w_unused;

    assign w_wr     = chipselect & ~write_n;
    assign w_wdata  = writedata[WIDTH-1:0];
    assign w_unused = &{1'b0, writedata};

    otg_hpi_pio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_async (in_port),
        .o_sync  (w_sync_in),
        .o_edge  (w_edge)
    );

    // Control registers: data, direction and mask, plus optional set/clear aliases.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data_out <= RESET_VALUE;
            r_dir      <= DIR_RESET;
            r_irq_mask <= '0;
        end else if (w_wr) begin
            case (address)
                ADDR_DATA:    r_data_out <= w_wdata;
                ADDR_DIR:     r_dir      <= w_wdata;
                ADDR_IRQMASK: r_irq_mask <= w_wdata;
`ifdef OTG_HPI_PIO_SETCLR_EN
                ADDR_OUTSET:  r_data_out <= r_data_out | w_wdata;
                ADDR_OUTCLR:  r_data_out <= r_data_out & ~w_wdata;
`endif
                default: ;
            endcase
        end
    end

    assign w_cap_clr = (w_wr && address == ADDR_EDGECAP) ? w_wdata : '0;

    // Edge capture: write-1-to-clear, but a fresh edge on an input bit wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edge_cap <= '0;
        end else begin
            r_edge_cap <= (r_edge_cap & ~w_cap_clr) | (w_edge & ~r_dir);
        end
    end

    // Combinational read mux; set/clear and reserved offsets read as zero.
    always_comb begin
        w_read = '0;
        if (chipselect) begin
            case (address)
                ADDR_DATA:    w_read[WIDTH-1:0] = (w_sync_in & ~r_dir) | (r_data_out & r_dir);
                ADDR_DIR:     w_read[WIDTH-1:0] = r_dir;
                ADDR_IRQMASK: w_read[WIDTH-1:0] = r_irq_mask;
                ADDR_EDGECAP: w_read[WIDTH-1:0] = r_edge_cap;
                default:      w_read = '0;
            endcase
        end
    end

    assign readdata = w_read;
    assign out_port = r_data_out;
    assign oe       = r_dir;
    assign irq      = |(r_edge_cap & r_irq_mask);

endmodule

// File: tb/tb_otg_hpi_pio.sv
// tb/tb_otg_hpi_pio.sv - self-checking bench for otg_hpi_pio
`timescale 1ns/1ps
module tb_otg_hpi_pio;

    localparam int         W  = 4;
    localparam int         SS = 2;
    localparam int         ET = 0;
    localparam logic [3:0] RV = 4'hA;
    localparam logic [3:0] DR = 4'hF;
`ifdef OTG_HPI_PIO_SETCLR_EN
    localparam bit SETCLR = 1'b1;
`else
    localparam bit SETCLR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic [2:0]   address;
    logic         chipselect;
    logic         write_n;
    logic [31:0]  writedata;
    logic [31:0]  readdata;
    logic [W-1:0] in_port;
    logic [W-1:0] out_port;
    logic [W-1:0] oe;
    logic         irq;

    int checks = 0;
    int errors = 0;

    otg_hpi_pio #(
        .WIDTH       (W),
        .RESET_VALUE (RV),
        .DIR_RESET   (DR),
        .EDGE_TYPE   (ET),
        .SYNC_STAGES (SS)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .out_port   (out_port),
        .oe         (oe),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // Reference model: architectural registers plus the pin samples of past edges.
    logic [3:0] m_out, m_dir, m_mask, m_cap;
    logic [3:0] m_pin [SS+1];   // m_pin[k] = in_port as sampled k+1 edges ago

    task automatic model_reset();
        m_out = RV; m_dir = DR; m_mask = '0; m_cap = '0;
        for (int k = 0; k <= SS; k++) m_pin[k] = '0;
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] a, input logic cs);
        logic [31:0] r;
        logic [3:0]  pins_now;
        r = '0;
        pins_now = m_pin[SS-1];
        if (cs) begin
            if (a == 3'd0) r[3:0] = (pins_now & ~m_dir) | (m_out & m_dir);
            else if (a == 3'd1) r[3:0] = m_dir;
            else if (a == 3'd2) r[3:0] = m_mask;
            else if (a == 3'd3) r[3:0] = m_cap;
        end
        return r;
    endfunction

    task automatic model_edge();
        logic [3:0] now_v, before_v, rose, clr;
        logic       wr;
        now_v    = m_pin[SS-1];
        before_v = m_pin[SS];
        rose     = now_v & ~before_v;
        wr       = chipselect && !write_n;
        clr      = (wr && address == 3'd3) ? writedata[3:0] : 4'h0;
        m_cap    = (m_cap & ~clr) | (rose & ~m_dir);
        if (wr) begin
            if (address == 3'd0) m_out = writedata[3:0];
            else if (address == 3'd1) m_dir = writedata[3:0];
            else if (address == 3'd2) m_mask = writedata[3:0];
            else if (address == 3'd4 && SETCLR) m_out = m_out | writedata[3:0];
            else if (address == 3'd5 && SETCLR) m_out = m_out & ~writedata[3:0];
        end
        for (int k = SS; k > 0; k--) m_pin[k] = m_pin[k-1];
        m_pin[0] = in_port;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out_port"}, 32'(out_port), 32'(m_out));
        chk({tag, ".oe"},       32'(oe),       32'(m_dir));
        chk({tag, ".irq"},      32'(irq),      32'(|(m_cap & m_mask)));
        chk({tag, ".readdata"}, readdata,      model_read(address, chipselect));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic bus(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] d);
        chipselect = cs; write_n = wn; address = a; writedata = d;
    endtask

    task automatic steps(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    initial begin
        reset_n = 1'b0;
        bus(1'b0, 1'b1, 3'd0, 32'h0);
        in_port = '0;
        model_reset();

        // Reset state
        #12;
        bus(1'b1, 1'b1, 3'd0, 32'h0);
        #1;
        chk("rst.out_port", 32'(out_port), 32'hA);
        chk("rst.oe",       32'(oe),       32'hF);
        chk("rst.irq",      32'(irq),      32'h0);
        chk("rst.data",     readdata,      32'hA);
        check_all("rst");
        reset_n = 1'b1;

        // Direction split and input latency
        bus(1'b1, 1'b0, 3'd1, 32'h3);
        in_port = 4'hC;
        step("dir_wr");
        bus(1'b1, 1'b1, 3'd0, 32'h0);
        step("sync2");
        chk("data_mixed", readdata, 32'hE);
        chk("out_low", 32'(out_port[1:0]), 32'h2);
        steps(2, "settle");

        // Rising edge capture with IRQ mask on bit 2
        bus(1'b1, 1'b0, 3'd2, 32'h4);
        in_port = 4'h0;
        step("mask_wr");
        bus(1'b1, 1'b1, 3'd0, 32'h0);
        steps(3, "low");
        bus(1'b1, 1'b0, 3'd3, 32'hF);
        step("cap_clr");
        bus(1'b1, 1'b1, 3'd3, 32'h0);
        in_port = 4'h4;
        steps(3, "rise");
        chk("cap_bit2", readdata, 32'h4);
        chk("irq_set", 32'(irq), 32'h1);
        bus(1'b1, 1'b0, 3'd3, 32'h4);
        step("cap_w1c");
        chk("irq_clr", 32'(irq), 32'h0);

        // Clear write colliding with a new edge: set wins
        bus(1'b1, 1'b1, 3'd3, 32'h0);
        in_port = 4'h0;
        steps(3, "low2");
        in_port = 4'h4;
        steps(3, "rise2");
        in_port = 4'h0;
        steps(3, "low3");
        in_port = 4'h4;
        steps(2, "rise3");
        bus(1'b1, 1'b0, 3'd3, 32'h4);
        step("collide");
        bus(1'b1, 1'b1, 3'd3, 32'h0);
        #1;
        chk("collide_irq", 32'(irq), 32'h1);
        chk("collide_cap", readdata, 32'h4);

        // Set/clear aliases
        bus(1'b1, 1'b0, 3'd0, 32'h0);
        step("data0");
        bus(1'b1, 1'b0, 3'd4, 32'h5);
        step("outset");
        chk("outset_val", 32'(out_port), SETCLR ? 32'h5 : 32'h0);
        bus(1'b1, 1'b0, 3'd5, 32'h1);
        step("outclr");
        chk("outclr_val", 32'(out_port), SETCLR ? 32'h4 : 32'h0);

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            bus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                3'($urandom_range(0, 7)), $urandom);
            if ($urandom_range(0, 2) == 0) in_port = 4'($urandom);
            step("rand");
        end

        // Reset asserted in the middle of a DATA write
        bus(1'b1, 1'b0, 3'd0, 32'hF);
        in_port = 4'hF;
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("midrst.out_port", 32'(out_port), 32'hA);
        chk("midrst.oe",       32'(oe),       32'hF);
        chk("midrst.irq",      32'(irq),      32'h0);
        bus(1'b1, 1'b1, 3'd3, 32'h0);
        #1;
        chk("midrst.cap", readdata, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        steps(4, "post_rst");
        chk("post_rst.cap", readdata, 32'h0);
        chk("post_rst.out", 32'(out_port), 32'hA);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/otg_hpi_pio.md
# otg_hpi_pio

Parametrised Avalon-MM general-purpose I/O port for the OTG/HPI control path. It replaces the single-bit output-only chip-select register with a WIDTH-bit port. Each bit has a per-bit direction and an input synchroniser, and the port has edge-capture registers and a maskable level interrupt to the Nios II IRQ line. It sits on the system interconnect as a zero-wait-state slave, and its pins connect to the CY7C67200 HPI control signals (CS, RD, WR, RST, INT).

## Interface
Parameters:
- WIDTH, 4: port width, 1..32.
- RESET_VALUE, 0: reset value of the output data register, WIDTH bits.
- DIR_RESET, 0: reset value of the direction register; 1 = output.
- EDGE_TYPE, 0: capture edge; 0 rising, 1 falling, 2 any.
- SYNC_STAGES, 2: input synchroniser depth, 2..3.

Ports:
- clk, input, 1: system clock.
- reset_n, input, 1: asynchronous, active-low reset.
- address, input, 3: register word offset.
- chipselect, input, 1: slave select.
- write_n, input, 1: active-low write strobe.
- writedata, input, 32: write data; bits above WIDTH ignored.
- readdata, output, 32: read data; bits above WIDTH read 0.
- in_port, input, WIDTH: asynchronous pin inputs.
- out_port, output, WIDTH: output data register.
- oe, output, WIDTH: direction register; the top level drives tristates with it.
- irq, output, 1: level interrupt.

## Operation
- All registers clear or load on reset_n low, asynchronously:
  - data_out = RESET_VALUE; dir = DIR_RESET; irq_mask = 0; edge_cap = 0.
  - Synchroniser flops reset to 0.
- A write occurs when chipselect=1 and write_n=0. Reads are combinational from address whenever chipselect=1; readdata = 0 otherwise.
- Register map:
  - 0 DATA: read = (sync_in & ~dir) | (data_out & dir); write = data_out.
  - 1 DIR: read/write direction.
  - 2 IRQMASK: read/write interrupt mask.
  - 3 EDGECAP: read = edge_cap; write 1 clears that bit, write 0 has no effect.
  - 4 OUTSET: write sets data_out bits where writedata=1; reads 0.
  - 5 OUTCLR: write clears data_out bits where writedata=1; reads 0.
  - 6, 7: reserved; read 0, writes ignored.
- Edge detect works on the synchronised input and a one-cycle-delayed copy, for input-direction bits only. Output bits never set edge_cap.
- If a clear write and a new edge hit the same bit in the same cycle, the set wins and the bit stays 1.
- irq = |(edge_cap & irq_mask), taken combinationally from the registers.

## Timing
- Register writes take effect at the clk edge that samples the write. The new value appears on out_port/oe/readdata the following cycle.
- Input latency: a change on in_port is visible in DATA after SYNC_STAGES rising edges.
- edge_cap sets one cycle after the synchronised value changes. irq asserts in that same cycle when the bit's mask is set.
- A toggle narrower than one clk period may be missed. Input must be stable for ≥2 cycles to be guaranteed capture.
- Changing dir from output to input does not generate a spurious edge: the delayed copy tracks the synchroniser continuously.
- Reset asserted mid-write: the write is lost and all outputs take their reset values immediately.

## Configuration
- OTG_HPI_PIO_SETCLR_EN defined: OUTSET/OUTCLR at offsets 4/5 operate as described above.
- Macro undefined: offsets 4 and 5 behave as reserved (read 0, writes ignored), and the set/clear logic is not built.

## Structure
- Package otg_hpi_pio_pkg holds:
  - register offset localparams ADDR_DATA..ADDR_OUTCLR;
  - edge type constants EDGE_RISE, EDGE_FALL, EDGE_ANY.
- Sub-module otg_hpi_pio_sync: a per-bus SYNC_STAGES flop chain plus delayed copy, outputting sync_in and edge pulse vectors. It is instantiated once for the full WIDTH.

## Test plan
- Reset, WIDTH=4, RESET_VALUE=4'hA, DIR_RESET=4'hF -> out_port=A, oe=F, irq=0, read DATA=A.
- Write DIR=4'h3, drive in_port=4'hC -> after 2 cycles read DATA=C|(out_port&3); out_port low bits unchanged.
- EDGE_TYPE=0, IRQMASK=4'h4, in_port bit2 rising -> EDGECAP=4, irq=1 at sync+1 cycle. Write EDGECAP=4 -> irq=0 next cycle.
- Clear EDGECAP bit2 in the same cycle a new rising edge arrives -> bit stays 1, irq stays 1.
- Macro defined, data_out=0: write OUTSET=5 then OUTCLR=1 -> out_port=5, then 4. Macro undefined: same writes leave out_port=0.
- Assert reset_n mid-write of DATA=F -> out_port=RESET_VALUE, edge_cap=0, no capture on release.
